// File: rtl/multicycle_sequencer.sv
// Multicycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB control with a memory-wait timeout.
// Optional instr_count performance counter is enabled by defining SEQ_PERF_COUNTERS_EN.
module multicycle_sequencer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] opcode,
  input  logic        cond_pass,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic [2:0]  alu_control,
  output logic        alu_src,
  output logic        reg_dst,
  output logic        flags_write,
  output logic        instr_done,
  output logic        fault,
  output logic [2:0]  state
`ifdef SEQ_PERF_COUNTERS_EN
  ,
  output logic [31:0] instr_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    C_NOP = 3'd0,
    C_MOV = 3'd1,
    C_ADD = 3'd2,
    C_SUB = 3'd3,
    C_CMP = 3'd4,
    C_LDR = 3'd5,
    C_STR = 3'd6,
    C_BR  = 3'd7
  } cls_t;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(TIMEOUT_CYCLES - 1);

  state_t        state_q;
  state_t        state_d;
  cls_t          cls_q;
  cls_t          dec_cls;
  logic [2:0]    alu_q;
  logic [2:0]    dec_alu;
  logic          src_q;
  logic          dec_src;
  logic          dst_q;
  logic          dec_dst;
  logic [CW-1:0] wait_cnt;
  logic          wait_limit;
  logic          end_instr;

  // Opcode classification; only meaningful while in DECODE, where it is captured.
  always_comb begin
    dec_cls = C_NOP;
    dec_alu = 3'b000;
    dec_src = 1'b0;
    dec_dst = 1'b0;
    case (opcode)
      12'he1a: begin dec_cls = C_MOV; end
      12'he3a: begin dec_cls = C_MOV; dec_dst = 1'b1; end
      12'he08: begin dec_cls = C_ADD; dec_alu = 3'b010; dec_src = 1'b1; end
      12'he28: begin dec_cls = C_ADD; dec_alu = 3'b010; dec_src = 1'b1; dec_dst = 1'b1; end
      12'he04: begin dec_cls = C_SUB; dec_alu = 3'b110; dec_src = 1'b1; end
      12'he24: begin dec_cls = C_SUB; dec_alu = 3'b110; dec_src = 1'b1; dec_dst = 1'b1; end
      12'he15: begin dec_cls = C_CMP; dec_alu = 3'b110; dec_src = 1'b1; end
      12'he35: begin dec_cls = C_CMP; dec_alu = 3'b110; dec_src = 1'b1; dec_dst = 1'b1; end
      12'he59: begin dec_cls = C_LDR; dec_alu = 3'b010; dec_src = 1'b1; dec_dst = 1'b1; end
      12'he58: begin dec_cls = C_STR; dec_alu = 3'b010; dec_src = 1'b1; dec_dst = 1'b1; end
      default: begin
        if (opcode[7:4] == 4'hA) begin
          dec_cls = C_BR;
          dec_alu = opcode[3] ? 3'b110 : 3'b010;
          dec_src = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latched decode stays frozen from DECODE until the next instruction's DECODE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cls_q <= C_NOP;
      alu_q <= 3'b000;
      src_q <= 1'b0;
      dst_q <= 1'b0;
    end else if (state_q == S_DECODE) begin
      cls_q <= dec_cls;
      alu_q <= dec_alu;
      src_q <= dec_src;
      dst_q <= dec_dst;
    end
  end

  // Wait counter restarts on every state change, so each FETCH/MEM entry counts from 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state_d != state_q) begin
      wait_cnt <= '0;
    end else if (state_q == S_FETCH || state_q == S_MEM) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  assign wait_limit = (wait_cnt == WAIT_LIMIT);

  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    flags_write = 1'b0;
    instr_done  = 1'b0;
    fault       = 1'b0;
    end_instr   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (wait_limit) begin
          state_d = S_FAULT;
        end
      end
      S_DECODE: begin
        if (dec_cls == C_NOP) end_instr = 1'b1;
        else                  state_d   = S_EXEC;
      end
      S_EXEC: begin
        case (cls_q)
          C_MOV, C_ADD, C_SUB: state_d = S_WB;
          C_LDR, C_STR:        state_d = S_MEM;
          C_CMP: begin
            flags_write = 1'b1;
            end_instr   = 1'b1;
          end
          C_BR: begin
            pc_write  = cond_pass;
            end_instr = 1'b1;
          end
          default: end_instr = 1'b1;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (cls_q == C_STR);
        if (mem_ready) begin
          if (cls_q == C_STR) end_instr = 1'b1;
          else                state_d   = S_WB;
        end else if (wait_limit) begin
          state_d = S_FAULT;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (cls_q == C_LDR);
        end_instr  = 1'b1;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (end_instr) begin
      instr_done = 1'b1;
      state_d    = start ? S_FETCH : S_IDLE;
    end
  end

  // Datapath controls come only from the latched decode, and only in the execute-side states.
  always_comb begin
    alu_control = 3'b000;
    alu_src     = 1'b0;
    reg_dst     = 1'b0;
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      alu_control = alu_q;
      alu_src     = src_q;
      reg_dst     = dst_q;
    end
  end

  assign state = state_q;

`ifdef SEQ_PERF_COUNTERS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_count <= 32'd0;
    end else if (instr_done) begin
      instr_count <= instr_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized bench for multicycle_sequencer: a per-instruction trace model builds the expected
// cycle-by-cycle outputs, then one process drives the inputs and compares every cycle.
module tb_multicycle_sequencer;

  localparam int TIMEOUT = 16;
  localparam int K_NOP = 0, K_MOV = 1, K_ADD = 2, K_SUB = 3, K_CMP = 4, K_LDR = 5, K_STR = 6, K_BR = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] opcode = 12'h000;
  logic        cond_pass = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, ir_write, pc_write, reg_write, mem_to_reg;
  logic [2:0]  alu_control;
  logic        alu_src, reg_dst, flags_write, instr_done, fault;
  logic [2:0]  state;
`ifdef SEQ_PERF_COUNTERS_EN
  logic [31:0] instr_count;
`endif

  multicycle_sequencer #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .cond_pass(cond_pass),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .alu_control(alu_control), .alu_src(alu_src), .reg_dst(reg_dst),
    .flags_write(flags_write), .instr_done(instr_done), .fault(fault), .state(state)
`ifdef SEQ_PERF_COUNTERS_EN
    , .instr_count(instr_count)
`endif
  );

  always #5 clk = ~clk;

  // One cycle: inputs to apply plus the outputs expected (or observed) in that cycle.
  typedef struct {
    logic        rst, start, cond_pass, mem_ready;
    logic [11:0] opcode;
    logic        mem_req, mem_we, ir_write, pc_write, reg_write, mem_to_reg;
    logic [2:0]  alu;
    logic        alu_src, reg_dst, flags_write, instr_done, fault;
    logic [2:0]  state;
  } cyc_t;

  cyc_t tq[$];
  cyc_t obs[$];
  int   checks = 0;
  int   errors = 0;
  bit   at_idle = 1'b1;

  function automatic cyc_t blank(input logic [2:0] st);
    cyc_t c;
    c = '{default: '0};
    c.start     = 1'($urandom_range(0, 1));
    c.opcode    = 12'($urandom);
    c.cond_pass = 1'($urandom_range(0, 1));
    c.mem_ready = 1'($urandom_range(0, 1));
    c.state     = st;
    return c;
  endfunction

  task automatic decode(input logic [11:0] op, output int cls, output logic [2:0] alu,
                        output logic src, output logic dst);
    cls = K_NOP; alu = 3'b000; src = 1'b0; dst = 1'b0;
    case (op)
      12'he1a: cls = K_MOV;
      12'he3a: begin cls = K_MOV; dst = 1'b1; end
      12'he08: begin cls = K_ADD; alu = 3'b010; src = 1'b1; end
      12'he28: begin cls = K_ADD; alu = 3'b010; src = 1'b1; dst = 1'b1; end
      12'he04: begin cls = K_SUB; alu = 3'b110; src = 1'b1; end
      12'he24: begin cls = K_SUB; alu = 3'b110; src = 1'b1; dst = 1'b1; end
      12'he15: begin cls = K_CMP; alu = 3'b110; src = 1'b1; end
      12'he35: begin cls = K_CMP; alu = 3'b110; src = 1'b1; dst = 1'b1; end
      12'he59: begin cls = K_LDR; alu = 3'b010; src = 1'b1; dst = 1'b1; end
      12'he58: begin cls = K_STR; alu = 3'b010; src = 1'b1; dst = 1'b1; end
      default: if (op[7:4] == 4'hA) begin
        cls = K_BR; alu = op[3] ? 3'b110 : 3'b010; src = 1'b1;
      end
    endcase
  endtask

  task automatic push_reset(input int n);
    cyc_t c;
    for (int k = 0; k < n; k++) begin
      c = blank(3'd0);
      c.rst = 1'b1;
      tq.push_back(c);
    end
    at_idle = 1'b1;
  endtask

  task automatic push_start(input int idle_n);
    cyc_t c;
    for (int k = 0; k < idle_n; k++) begin
      c = blank(3'd0);
      c.start = 1'b0;
      tq.push_back(c);
    end
    c = blank(3'd0);
    c.start = 1'b1;
    tq.push_back(c);
    at_idle = 1'b0;
  endtask

  task automatic push_end(input cyc_t c);
    c.instr_done = 1'b1;
    at_idle = !c.start;
    tq.push_back(c);
  endtask

  // A memory wait: lat idle cycles then mem_ready; TIMEOUT cycles without it means FAULT.
  task automatic push_access(input logic [2:0] st, input logic we, input logic [2:0] alu,
                             input logic src, input logic dst, input int lat,
                             input int abort_at, output int status);
    cyc_t c;
    status = 0;
    for (int k = 0; k < TIMEOUT; k++) begin
      if (k == abort_at) begin
        push_reset(1 + int'($urandom_range(0, 1)));
        status = 2;
        return;
      end
      c = blank(st);
      c.mem_req = 1'b1; c.mem_we = we; c.alu = alu; c.alu_src = src; c.reg_dst = dst;
      c.mem_ready = (k == lat);
      tq.push_back(c);
      if (k == lat) return;
    end
    for (int k = 0; k < 3; k++) begin
      c = blank(3'd6);
      c.fault = 1'b1;
      tq.push_back(c);
    end
    push_reset(2);
    status = 1;
  endtask

  task automatic gen_instr(input logic [11:0] op, input int lf, input int lm, input logic cond,
                           input int abort_mem, input logic end_start, output int first_idx);
    cyc_t c;
    int cls, st;
    logic [2:0] alu;
    logic src, dst;
    if (at_idle) push_start(int'($urandom_range(0, 2)));
    first_idx = tq.size();
    push_access(3'd1, 1'b0, 3'b000, 1'b0, 1'b0, lf, -1, st);
    if (st != 0) return;
    c = tq.pop_back();
    c.ir_write = 1'b1; c.pc_write = 1'b1;
    tq.push_back(c);
    decode(op, cls, alu, src, dst);
    c = blank(3'd2);
    c.opcode = op;
    if (cls == K_NOP) begin
      c.start = end_start;
      push_end(c);
      return;
    end
    tq.push_back(c);
    c = blank(3'd3);
    c.alu = alu; c.alu_src = src; c.reg_dst = dst;
    if (cls == K_CMP || cls == K_BR) begin
      c.flags_write = (cls == K_CMP);
      c.cond_pass   = cond;
      c.pc_write    = (cls == K_BR) && cond;
      c.start       = end_start;
      push_end(c);
      return;
    end
    tq.push_back(c);
    if (cls == K_LDR || cls == K_STR) begin
      push_access(3'd4, cls == K_STR, alu, src, dst, lm, abort_mem, st);
      if (st != 0) return;
      if (cls == K_STR) begin
        c = tq.pop_back();
        c.start = end_start;
        push_end(c);
        return;
      end
    end
    c = blank(3'd5);
    c.alu = alu; c.alu_src = src; c.reg_dst = dst;
    c.reg_write = 1'b1; c.mem_to_reg = (cls == K_LDR);
    c.start = end_start;
    push_end(c);
  endtask

  function automatic int pick_lat();
    int r;
    r = int'($urandom_range(0, 19));
    if (r < 14) return r % 4;
    if (r < 18) return TIMEOUT - 1;
    return TIMEOUT;
  endfunction

  function automatic logic [11:0] pick_op();
    logic [11:0] known [10];
    int r;
    known = '{12'he1a, 12'he3a, 12'he08, 12'he28, 12'he04, 12'he24, 12'he15, 12'he35, 12'he59, 12'he58};
    r = int'($urandom_range(0, 13));
    if (r < 10) return known[r];
    if (r < 12) return {4'($urandom), 4'hA, 4'($urandom)};
    return 12'($urandom);
  endfunction

  task automatic applyStimulus(input cyc_t c);
    rst       = c.rst;
    start     = c.start;
    opcode    = c.opcode;
    cond_pass = c.cond_pass;
    mem_ready = c.mem_ready;
  endtask

  task automatic checkOutput(input string name, input int cyc, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
    end
  endtask

  initial begin
    int iA, iB, iC0, iC1, iD, iE, iF, dummy;
    int exp_cnt;
    cyc_t o;

    push_reset(3);
    gen_instr(12'he28, 0, 0, 1'b0, -1, 1'b0, iA);
    gen_instr(12'he59, 0, 2, 1'b0, -1, 1'b0, iB);
    gen_instr(12'h0A8, 0, 0, 1'b0, -1, 1'b0, iC0);
    gen_instr(12'h0A8, 0, 0, 1'b1, -1, 1'b0, iC1);
    gen_instr(12'he1a, TIMEOUT, 0, 1'b0, -1, 1'b0, iD);
    gen_instr(12'he58, 0, 5, 1'b0, 2, 1'b0, iE);
    gen_instr(12'he3a, TIMEOUT - 1, 0, 1'b0, -1, 1'b0, iF);
    for (int n = 0; n < 250; n++) begin
      gen_instr(pick_op(), pick_lat(), pick_lat(), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, 3)) : -1,
                1'($urandom_range(0, 1)), dummy);
    end
    push_reset(1);

    exp_cnt = 0;
    for (int i = 0; i < tq.size(); i++) begin
      @(posedge clk);
      #1;
      applyStimulus(tq[i]);
      @(negedge clk);
      o = tq[i];
      o.mem_req = mem_req; o.mem_we = mem_we; o.ir_write = ir_write; o.pc_write = pc_write;
      o.reg_write = reg_write; o.mem_to_reg = mem_to_reg; o.alu = alu_control;
      o.alu_src = alu_src; o.reg_dst = reg_dst; o.flags_write = flags_write;
      o.instr_done = instr_done; o.fault = fault; o.state = state;
      obs.push_back(o);
      checkOutput("state",       i, 32'(state),       32'(tq[i].state));
      checkOutput("mem_req",     i, 32'(mem_req),     32'(tq[i].mem_req));
      checkOutput("mem_we",      i, 32'(mem_we),      32'(tq[i].mem_we));
      checkOutput("ir_write",    i, 32'(ir_write),    32'(tq[i].ir_write));
      checkOutput("pc_write",    i, 32'(pc_write),    32'(tq[i].pc_write));
      checkOutput("reg_write",   i, 32'(reg_write),   32'(tq[i].reg_write));
      checkOutput("mem_to_reg",  i, 32'(mem_to_reg),  32'(tq[i].mem_to_reg));
      checkOutput("alu_control", i, 32'(alu_control), 32'(tq[i].alu));
      checkOutput("alu_src",     i, 32'(alu_src),     32'(tq[i].alu_src));
      checkOutput("reg_dst",     i, 32'(reg_dst),     32'(tq[i].reg_dst));
      checkOutput("flags_write", i, 32'(flags_write), 32'(tq[i].flags_write));
      checkOutput("instr_done",  i, 32'(instr_done),  32'(tq[i].instr_done));
      checkOutput("fault",       i, 32'(fault),       32'(tq[i].fault));
`ifdef SEQ_PERF_COUNTERS_EN
      if (tq[i].rst) exp_cnt = 0;
      checkOutput("instr_count", i, instr_count, 32'(exp_cnt));
      if (!tq[i].rst && tq[i].instr_done) exp_cnt++;
`endif
    end

    // Hand-computed expectations for the directed scenarios at the head of the run.
    checkOutput("addimm_state0", iA,     32'(obs[iA].state),       32'd1);
    checkOutput("addimm_state1", iA + 1, 32'(obs[iA+1].state),     32'd2);
    checkOutput("addimm_state2", iA + 2, 32'(obs[iA+2].state),     32'd3);
    checkOutput("addimm_state3", iA + 3, 32'(obs[iA+3].state),     32'd5);
    checkOutput("addimm_regwr",  iA + 3, 32'(obs[iA+3].reg_write), 32'd1);
    checkOutput("addimm_alu",    iA + 3, 32'(obs[iA+3].alu),       32'h2);
    checkOutput("addimm_dst",    iA + 3, 32'(obs[iA+3].reg_dst),   32'd1);
    checkOutput("addimm_done",   iA + 3, 32'(obs[iA+3].instr_done), 32'd1);
    for (int k = 3; k < 6; k++) begin
      checkOutput("ldr_memreq", iB + k, 32'(obs[iB+k].mem_req), 32'd1);
      checkOutput("ldr_memwe",  iB + k, 32'(obs[iB+k].mem_we),  32'd0);
    end
    checkOutput("ldr_wb_state", iB + 6, 32'(obs[iB+6].state),      32'd5);
    checkOutput("ldr_regwr",    iB + 6, 32'(obs[iB+6].reg_write),  32'd1);
    checkOutput("ldr_memtoreg", iB + 6, 32'(obs[iB+6].mem_to_reg), 32'd1);
    checkOutput("br_alu_nc",    iC0 + 2, 32'(obs[iC0+2].alu),      32'h6);
    checkOutput("br_pcw_nc",    iC0 + 2, 32'(obs[iC0+2].pc_write), 32'd0);
    checkOutput("br_alu_c",     iC1 + 2, 32'(obs[iC1+2].alu),      32'h6);
    checkOutput("br_pcw_c",     iC1 + 2, 32'(obs[iC1+2].pc_write), 32'd1);
    checkOutput("to_last_fetch", iD + 15, 32'(obs[iD+15].state), 32'd1);
    checkOutput("to_fault",      iD + 16, 32'(obs[iD+16].state), 32'd6);
    checkOutput("to_sticky",     iD + 18, 32'(obs[iD+18].fault), 32'd1);
    checkOutput("to_rst_state",  iD + 19, 32'(obs[iD+19].state), 32'd0);
    checkOutput("to_rst_fault",  iD + 19, 32'(obs[iD+19].fault), 32'd0);
    checkOutput("str_mem_we",    iE + 4, 32'(obs[iE+4].mem_we),  32'd1);
    checkOutput("str_rst_req",   iE + 5, 32'(obs[iE+5].mem_req), 32'd0);
    checkOutput("str_rst_we",    iE + 5, 32'(obs[iE+5].mem_we),  32'd0);
    checkOutput("str_rst_state", iE + 5, 32'(obs[iE+5].state),   32'd0);
    checkOutput("limit_irw",     iF + 15, 32'(obs[iF+15].ir_write), 32'd1);
    checkOutput("limit_decode",  iF + 16, 32'(obs[iF+16].state),    32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
